// File: rtl/strobe_serial_rx_if.sv
// Bundle of the strobe, serial line, consumer handshake and status signals
// shared between the strobe-paced serial receiver and its surroundings.
interface strobe_serial_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 shift_en;
    logic                 serial_in;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;
    logic                 busy;

    // Driver side: divider/line/consumer.
    modport master (
        output shift_en,
        output serial_in,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  framing_error,
        input  overrun_error,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  shift_en,
        input  serial_in,
        input  data_read,
        output rx_data,
        output data_ready,
        output framing_error,
        output overrun_error,
        output busy
    );
endinterface

// File: rtl/strobe_serial_rx.sv
// Strobe-paced serial-to-parallel receiver: start bit (0), DATA_BITS data
// bits, stop bit (1). Completed words are held for a ready/read handshake,
// with sticky framing and overrun flags.
module strobe_serial_rx #(
    parameter int unsigned DATA_BITS = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    strobe_serial_rx_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StStop = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 framing_error_q, framing_error_d;
    logic                 overrun_error_q, overrun_error_d;
    logic [DATA_BITS-1:0] shifted;
    logic                 consume;

    assign consume = bus.data_read & data_ready_q;

    // Next shift register contents for the configured bit order.
    always_comb begin
        if (LSB_FIRST) begin
            shifted = {bus.serial_in, shreg_q[DATA_BITS-1:1]};
        end else begin
            shifted = {shreg_q[DATA_BITS-2:0], bus.serial_in};
        end
    end

    // Frame FSM, handshake and error flag next-state.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shreg_d         = shreg_q;
        rx_data_d       = rx_data_q;
        data_ready_d    = data_ready_q;
        framing_error_d = framing_error_q;
        overrun_error_d = overrun_error_q;

        if (consume) begin
            data_ready_d    = 1'b0;
            overrun_error_d = 1'b0;
        end

        if (bus.shift_en) begin
            case (state_q)
                StIdle: begin
                    if (!bus.serial_in) begin
                        state_d         = StData;
                        cnt_d           = '0;
                        framing_error_d = 1'b0;
                    end
                end
                StData: begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end
                StStop: begin
                    state_d = StIdle;
                    if (bus.serial_in) begin
                        rx_data_d    = shreg_q;
                        data_ready_d = 1'b1;
                        // A same-cycle read consumes the old word, so no overrun.
                        if (data_ready_q && !bus.data_read) begin
                            overrun_error_d = 1'b1;
                        end
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            shreg_q         <= '0;
            rx_data_q       <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shreg_q         <= shreg_d;
            rx_data_q       <= rx_data_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.framing_error = framing_error_q;
    assign bus.overrun_error = overrun_error_q;
    assign bus.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_strobe_serial_rx.sv
// Directed bench for strobe_serial_rx: one LSB-first and one MSB-first
// instance share the same stimulus; expected words go through a queue.
module tb_strobe_serial_rx;
    localparam int unsigned DB = 8;

    logic clk = 1'b0;
    logic rst;
    logic shift_en;
    logic serial_in;
    logic data_read;

    int checks = 0;
    int errors = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] last_word = '0;

    strobe_serial_rx_if #(.DATA_BITS(DB)) bus0 ();
    strobe_serial_rx_if #(.DATA_BITS(DB)) bus1 ();

    assign bus0.shift_en  = shift_en;
    assign bus0.serial_in = serial_in;
    assign bus0.data_read = data_read;
    assign bus1.shift_en  = shift_en;
    assign bus1.serial_in = serial_in;
    assign bus1.data_read = data_read;

    strobe_serial_rx #(.DATA_BITS(DB), .LSB_FIRST(1'b1)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    strobe_serial_rx #(.DATA_BITS(DB), .LSB_FIRST(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops all words pushed since the last check; the newest must be in rx_data.
    task automatic chk_word(input string tag, input logic [DB-1:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
        end else begin
            while (exp_q.size() > 0) last_word = exp_q.pop_front();
            chk(tag, 16'(obs), 16'(last_word));
        end
    endtask

    // One strobe after gap-1 idle cycles; returns at the negedge after the strobe edge.
    task automatic strobe_bit(input logic b, input int gap, input logic rd);
        repeat (gap - 1) @(negedge clk);
        @(negedge clk);
        serial_in = b;
        shift_en  = 1'b1;
        data_read = rd;
        @(negedge clk);
        shift_en  = 1'b0;
        data_read = 1'b0;
        serial_in = 1'b1;
    endtask

    // Data bits and stop bit of a frame whose start bit is already sent.
    task automatic send_tail(input logic [DB-1:0] w, input logic stop, input int gap,
                             input logic msb_first, input logic rd_on_stop);
        for (int i = 0; i < int'(DB); i++) begin
            strobe_bit(msb_first ? w[DB-1-i] : w[i], gap, 1'b0);
        end
        strobe_bit(stop, gap, rd_on_stop);
        if (stop) exp_q.push_back(w);
    endtask

    task automatic send_frame(input logic [DB-1:0] w, input logic stop, input logic rd_on_stop);
        strobe_bit(1'b0, 4, 1'b0);
        send_tail(w, stop, 4, 1'b0, rd_on_stop);
    endtask

    task automatic read_pulse();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] w;
        rst       = 1'b1;
        shift_en  = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rx_data", 16'(bus0.rx_data), 16'h0);
        chk("rst_ready", 16'(bus0.data_ready), 16'h0);
        chk("rst_busy", 16'(bus0.busy), 16'h0);

        // Idle line with strobes must not start anything.
        repeat (20) strobe_bit(1'b1, 1, 1'b0);
        chk("idle_rx_data", 16'(bus0.rx_data), 16'h0);
        chk("idle_ready", 16'(bus0.data_ready), 16'h0);
        chk("idle_ferr", 16'(bus0.framing_error), 16'h0);
        chk("idle_oerr", 16'(bus0.overrun_error), 16'h0);
        chk("idle_busy", 16'(bus0.busy), 16'h0);

        // Good frame, LSB first.
        send_frame(8'hA5, 1'b1, 1'b0);
        chk_word("a5_rx_data", bus0.rx_data);
        chk("a5_ready", 16'(bus0.data_ready), 16'h1);
        chk("a5_busy", 16'(bus0.busy), 16'h0);
        read_pulse();
        chk("a5_read_ready", 16'(bus0.data_ready), 16'h0);

        // Framing error keeps the previous word.
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("fe_flag", 16'(bus0.framing_error), 16'h1);
        chk("fe_ready", 16'(bus0.data_ready), 16'h0);
        chk("fe_rx_data", 16'(bus0.rx_data), 16'(last_word));
        strobe_bit(1'b0, 4, 1'b0);
        chk("fe_clear_at_start", 16'(bus0.framing_error), 16'h0);
        chk("busy_after_start", 16'(bus0.busy), 16'h1);
        send_tail(8'h81, 1'b1, 4, 1'b0, 1'b0);
        chk_word("81_rx_data", bus0.rx_data);
        chk("81_ferr", 16'(bus0.framing_error), 16'h0);
        read_pulse();

        // Overrun: two words with no read in between.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk_word("ovr_rx_data", bus0.rx_data);
        chk("ovr_ready", 16'(bus0.data_ready), 16'h1);
        chk("ovr_flag", 16'(bus0.overrun_error), 16'h1);
        read_pulse();
        chk("ovr_read_ready", 16'(bus0.data_ready), 16'h0);
        chk("ovr_read_flag", 16'(bus0.overrun_error), 16'h0);

        // Read coincides with the second stop strobe: no overrun.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        chk_word("simrd_rx_data", bus0.rx_data);
        chk("simrd_ready", 16'(bus0.data_ready), 16'h1);
        chk("simrd_oerr", 16'(bus0.overrun_error), 16'h0);
        read_pulse();

        // Reset after four data bits of 0xF0, then a clean frame.
        w = 8'hF0;
        strobe_bit(1'b0, 4, 1'b0);
        for (int i = 0; i < 4; i++) strobe_bit(w[i], 4, 1'b0);
        chk("mid_busy", 16'(bus0.busy), 16'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 16'(bus0.busy), 16'h0);
        chk("mid_rst_rx_data", 16'(bus0.rx_data), 16'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk_word("5a_rx_data", bus0.rx_data);
        chk("5a_ferr", 16'(bus0.framing_error), 16'h0);
        chk("5a_oerr", 16'(bus0.overrun_error), 16'h0);
        read_pulse();

        // Strobe held high every cycle, MSB-first instance.
        w = 8'hC3;
        @(negedge clk);
        shift_en  = 1'b1;
        serial_in = 1'b0;
        for (int i = 0; i < int'(DB); i++) begin
            @(negedge clk);
            serial_in = w[DB-1-i];
        end
        @(negedge clk);
        serial_in = 1'b1;
        @(negedge clk);
        shift_en = 1'b0;
        exp_q.push_back(w);
        chk_word("c3_msb_rx_data", bus1.rx_data);
        chk("c3_msb_ready", 16'(bus1.data_ready), 16'h1);
        chk("c3_msb_ferr", 16'(bus1.framing_error), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
